// File: rtl/insn_buf_pkg.sv
// Shared widths and defaults for the fetch-to-decode instruction buffer.
package insn_buf_pkg;

  localparam int INSN_BUF_DEPTH = 4;
  localparam int PC_W           = 30;
  localparam int INSN_W         = 32;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INSN_W-1:0] insn;
  } ib_entry_t;

  function automatic int ib_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/insn_buf.sv
// Show-ahead circular FIFO decoupling the IF stage from ID; flush/branch empties it.
module insn_buf
  import insn_buf_pkg::*;
#(
  parameter int DEPTH = INSN_BUF_DEPTH,
  localparam int PTR_W = ib_ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PC_W-1:0]   if_pc,
  input  logic [INSN_W-1:0] if_insn,
  input  logic              if_en,
  input  logic              ext_stall,
  input  logic              flush,
  input  logic              br_taken,
  input  logic              id_stall,
  output logic              buf_stall,
  output logic [PC_W-1:0]   ib_pc,
  output logic [INSN_W-1:0] ib_insn,
  output logic              ib_en,
  output logic [CNT_W-1:0]  ib_count
);

  ib_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;

  logic full;
  logic empty;
  logic kill;
  logic pop;
  logic push;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign kill  = flush | br_taken;
  assign pop   = !empty && !id_stall;
  // A full buffer still accepts a word when the head leaves in the same cycle.
  assign push  = if_en && !ext_stall && (!full || pop) && !kill;

  assign buf_stall = full && !pop && !kill;
  assign ib_en     = !empty;
  assign ib_count  = count;
  assign ib_pc     = empty ? '0 : mem[rd_ptr].pc;
  assign ib_insn   = empty ? '0 : mem[rd_ptr].insn;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (kill) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never reset; the output mux hides stale entries while empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr].pc   <= if_pc;
      mem[wr_ptr].insn <= if_insn;
    end
  end

endmodule

// File: tb/tb_insn_buf.sv
// Directed self-checking bench for insn_buf using immediate assertions.
module tb_insn_buf;

  logic        clk;
  logic        reset;
  logic [29:0] if_pc;
  logic [31:0] if_insn;
  logic        if_en;
  logic        ext_stall;
  logic        flush;
  logic        br_taken;
  logic        id_stall;
  logic        buf_stall;
  logic [29:0] ib_pc;
  logic [31:0] ib_insn;
  logic        ib_en;
  logic [2:0]  ib_count;

  int checks;
  int errors;

  insn_buf #(.DEPTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_pc     (if_pc),
    .if_insn   (if_insn),
    .if_en     (if_en),
    .ext_stall (ext_stall),
    .flush     (flush),
    .br_taken  (br_taken),
    .id_stall  (id_stall),
    .buf_stall (buf_stall),
    .ib_pc     (ib_pc),
    .ib_insn   (ib_insn),
    .ib_en     (ib_en),
    .ib_count  (ib_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] insn_of(input logic [29:0] pc);
    return 32'hCAFE_0000 | {2'b00, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present(input logic en, input logic [29:0] pc);
    if_en   = en;
    if_pc   = pc;
    if_insn = insn_of(pc);
  endtask

  // Head entry, its instruction word and the occupancy in one call.
  task automatic chk_head(input string tag, input logic [29:0] pc, input logic [2:0] cnt);
    chk({tag, "_en"}, ib_en, 1'b1);
    chk({tag, "_pc"}, ib_pc, pc);
    chk({tag, "_insn"}, ib_insn, insn_of(pc));
    chk({tag, "_count"}, ib_count, cnt);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_en"}, ib_en, 1'b0);
    chk({tag, "_pc"}, ib_pc, 30'h0);
    chk({tag, "_insn"}, ib_insn, 32'h0);
    chk({tag, "_count"}, ib_count, 3'd0);
  endtask

  task automatic fill(input logic [29:0] base, input int n);
    id_stall = 1'b1;
    for (int i = 0; i < n; i++) begin
      present(1'b1, base + 30'(i));
      tick();
    end
    present(1'b0, 30'h0);
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    ext_stall = 1'b0;
    flush     = 1'b0;
    br_taken  = 1'b0;
    id_stall  = 1'b0;
    present(1'b0, 30'h0);

    #3;
    chk_empty("reset");
    chk("reset_buf_stall", buf_stall, 1'b0);
    #9 reset = 1'b1;
    tick();

    // ext_stall blocks the push
    id_stall  = 1'b1;
    ext_stall = 1'b1;
    present(1'b1, 30'h50);
    tick();
    chk_empty("ext_stall");
    ext_stall = 1'b0;
    present(1'b0, 30'h0);

    // Fill to full, then the fifth word is refused
    id_stall = 1'b1;
    present(1'b1, 30'h100);
    tick();
    chk_head("fill_first", 30'h100, 3'd1);
    for (int i = 1; i < 4; i++) begin
      present(1'b1, 30'h100 + 30'(i));
      tick();
    end
    chk_head("fill_full", 30'h100, 3'd4);
    present(1'b1, 30'h104);
    #1;
    chk("fill_buf_stall", buf_stall, 1'b1);
    tick();
    chk_head("fill_refused", 30'h100, 3'd4);

    // Drain in order
    id_stall = 1'b0;
    present(1'b0, 30'h0);
    #1;
    chk("drain_buf_stall", buf_stall, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk_head("drain", 30'h100 + 30'(i), 3'(4 - i));
      tick();
    end
    chk_empty("drain_end");

    // Full simultaneous push/pop
    fill(30'h100, 4);
    id_stall = 1'b0;
    present(1'b1, 30'h104);
    #1;
    chk("pp_buf_stall", buf_stall, 1'b0);
    tick();
    present(1'b0, 30'h0);
    chk_head("pp_0", 30'h101, 3'd4);
    tick();
    chk_head("pp_1", 30'h102, 3'd3);
    tick();
    chk_head("pp_2", 30'h103, 3'd2);
    tick();
    chk_head("pp_3", 30'h104, 3'd1);
    tick();
    chk_empty("pp_end");

    // Flush beats push; the presented word never appears
    fill(30'h10, 3);
    chk_head("fl_pre", 30'h10, 3'd3);
    flush = 1'b1;
    present(1'b1, 30'h200);
    tick();
    flush = 1'b0;
    present(1'b0, 30'h0);
    chk_empty("fl_next");
    tick();
    chk_empty("fl_after");

    // Branch redirect beats pop
    fill(30'h20, 2);
    id_stall = 1'b0;
    br_taken = 1'b1;
    present(1'b1, 30'h210);
    tick();
    br_taken = 1'b0;
    present(1'b0, 30'h0);
    chk_empty("br_next");

    // Continuous push/pop across pointer wrap
    id_stall = 1'b0;
    for (int i = 0; i < 10; i++) begin
      present(1'b1, 30'(i));
      tick();
      chk_head("wrap", 30'(i), 3'd1);
    end
    present(1'b0, 30'h0);
    tick();
    chk_empty("wrap_end");

    // Asynchronous reset between edges
    fill(30'h40, 2);
    chk_head("rst_pre", 30'h40, 3'd2);
    reset = 1'b0;
    #1;
    chk_empty("rst_async");
    chk("rst_buf_stall", buf_stall, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    present(1'b1, 30'h300);
    tick();
    present(1'b0, 30'h0);
    chk_head("rst_push", 30'h300, 3'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
